// File: rtl/slow_memory_pl_if.sv
// Request/response bundle between a cache and slow_memory_pl.
// mem_wmask exists only when SLOW_MEM_BYTE_MASK_EN is defined.
interface slow_memory_pl_if #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_W         = 28
);
  localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
`ifdef SLOW_MEM_BYTE_MASK_EN
  logic [LINE_W/8-1:0] mem_wmask;
`endif
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

`ifdef SLOW_MEM_BYTE_MASK_EN
  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ready
  );
  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ready
  );
`else
  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );
  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
`endif
endinterface

// File: rtl/slow_memory_pl.sv
// Parametrised main-memory model with cycle-counted latency and a one-cycle mem_ready pulse.
// Define SLOW_MEM_BYTE_MASK_EN to enable per-byte write masking through mem_wmask.
module slow_memory_pl #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned MEM_LINES      = 256,
  parameter int unsigned ADDR_W         = 28,
  parameter int unsigned RD_LATENCY     = 15,
  parameter int unsigned WR_LATENCY     = 15
) (
  input logic              clk,
  input logic              rst_n,
  slow_memory_pl_if.slave  bus
);
  localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int unsigned IDX_W  = $clog2(MEM_LINES);
  localparam int unsigned LatMax = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CntW   = (LatMax > 1) ? $clog2(LatMax) : 1;
  localparam logic [CntW-1:0] RdCnt = CntW'(RD_LATENCY - 1);
  localparam logic [CntW-1:0] WrCnt = CntW'(WR_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              mem_we;
  logic [LINE_W-1:0] wr_line;

  // Storage is deliberately outside the reset domain: contents survive rst_n.
  logic [LINE_W-1:0] mem_q [MEM_LINES];

  // Upper address bits are ignored so accesses wrap modulo MEM_LINES.
  logic unused_addr;
  assign unused_addr = ^bus.mem_addr;

`ifdef SLOW_MEM_BYTE_MASK_EN
  logic [LINE_W/8-1:0] wmask_q, wmask_d;
  logic [LINE_W-1:0]   bit_mask;

  for (genvar b = 0; b < LINE_W / 8; b++) begin : g_mask
    assign bit_mask[8*b +: 8] = {8{wmask_q[b]}};
  end

  assign wr_line = (mem_q[idx_q] & ~bit_mask) | (wdata_q & bit_mask);
`else
  assign wr_line = wdata_q;
`endif

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
`ifdef SLOW_MEM_BYTE_MASK_EN
      wmask_q <= '0;
`endif
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
`ifdef SLOW_MEM_BYTE_MASK_EN
      wmask_q <= wmask_d;
`endif
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    read_d  = read_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
`ifdef SLOW_MEM_BYTE_MASK_EN
    wmask_d = wmask_q;
`endif
    ready_d = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.mem_read || bus.mem_write) begin
          read_d  = bus.mem_read;
          write_d = bus.mem_write;
          idx_d   = bus.mem_addr[IDX_W-1:0];
          wdata_d = bus.mem_wdata;
`ifdef SLOW_MEM_BYTE_MASK_EN
          wmask_d = bus.mem_wmask;
`endif
          // A read+write conflict completes on the read latency.
          cnt_d   = bus.mem_read ? RdCnt : WrCnt;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ready_d = 1'b1;
          state_d = StDone;
          if (read_q && !write_q) begin
            rdata_d = mem_q[idx_q];
          end
          mem_we = write_q && !read_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wr_line;
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = ready_q;

endmodule

// File: tb/tb_slow_memory_pl.sv
// Scoreboard bench for slow_memory_pl: three instances with different latencies/depths.
// Byte-mask vectors run only when SLOW_MEM_BYTE_MASK_EN is defined.
module tb_slow_memory_pl;
  localparam int unsigned LineW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Counts DUT (negedge) clock edges; read by driver and monitor on posedges.
  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  slow_memory_pl_if #(.WORD_W(32), .WORDS_PER_LINE(4), .ADDR_W(28)) bus0 ();
  slow_memory_pl_if #(.WORD_W(32), .WORDS_PER_LINE(4), .ADDR_W(28)) bus1 ();
  slow_memory_pl_if #(.WORD_W(32), .WORDS_PER_LINE(4), .ADDR_W(28)) bus2 ();

  slow_memory_pl #(
    .WORD_W(32), .WORDS_PER_LINE(4), .MEM_LINES(256), .ADDR_W(28),
    .RD_LATENCY(15), .WR_LATENCY(15)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  slow_memory_pl #(
    .WORD_W(32), .WORDS_PER_LINE(4), .MEM_LINES(256), .ADDR_W(28),
    .RD_LATENCY(3), .WR_LATENCY(7)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  slow_memory_pl #(
    .WORD_W(32), .WORDS_PER_LINE(4), .MEM_LINES(16), .ADDR_W(28),
    .RD_LATENCY(1), .WR_LATENCY(1)
  ) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

`ifdef SLOW_MEM_BYTE_MASK_EN
  logic [LineW/8-1:0] wmask_cur = '1;
  assign bus0.mem_wmask = wmask_cur;
  assign bus1.mem_wmask = wmask_cur;
  assign bus2.mem_wmask = wmask_cur;
`endif

  typedef struct {
    int              cyc;
    logic [LineW-1:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic [LineW-1:0] last_rd [3];
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [LineW-1:0] LineA = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [LineW-1:0] LineB = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [LineW-1:0] LineC = 128'h11111111_22222222_33333333_44444444;
  localparam logic [LineW-1:0] LineD = 128'hCAFEF00D_DEADBEEF_0BADC0DE_12345678;
  localparam logic [LineW-1:0] LineE = 128'h5A5A5A5A_A5A5A5A5_00FF00FF_FF00FF00;
  localparam logic [LineW-1:0] LineF = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;
  localparam logic [LineW-1:0] LineG = 128'h87654321_0FEDCBA9_11223344_55667788;

  task automatic check(input string name, input logic [LineW-1:0] act,
                       input logic [LineW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input int id);
    case (id)
      0:       return bus0.mem_ready;
      1:       return bus1.mem_ready;
      default: return bus2.mem_ready;
    endcase
  endfunction

  function automatic logic [LineW-1:0] get_rdata(input int id);
    case (id)
      0:       return bus0.mem_rdata;
      1:       return bus1.mem_rdata;
      default: return bus2.mem_rdata;
    endcase
  endfunction

  task automatic drive(input int id, input bit r, input bit w, input logic [27:0] a,
                       input logic [LineW-1:0] d);
    case (id)
      0: begin
        bus0.mem_read = r; bus0.mem_write = w; bus0.mem_addr = a; bus0.mem_wdata = d;
      end
      1: begin
        bus1.mem_read = r; bus1.mem_write = w; bus1.mem_addr = a; bus1.mem_wdata = d;
      end
      default: begin
        bus2.mem_read = r; bus2.mem_write = w; bus2.mem_addr = a; bus2.mem_wdata = d;
      end
    endcase
  endtask

  task automatic pop_check(input int id, input logic [LineW-1:0] rd);
    exp_t e;
    bit   have = 1'b0;
    case (id)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_ready dut%0d: got ready=1, expected ready=0 (cycle %0d)", id, cyc);
    end else begin
      check($sformatf("ready_cycle dut%0d", id), LineW'(cyc), LineW'(e.cyc));
      check($sformatf("rdata dut%0d", id), rd, e.rdata);
    end
  endtask

  // Monitor: every observed ready pulse must match the next expected completion.
  always @(posedge clk) begin
    if (bus0.mem_ready === 1'b1) pop_check(0, bus0.mem_rdata);
    if (bus1.mem_ready === 1'b1) pop_check(1, bus1.mem_rdata);
    if (bus2.mem_ready === 1'b1) pop_check(2, bus2.mem_rdata);
  end

  // Issue one transaction, then scramble addr/wdata while it is in flight.
  task automatic issue(input int id, input bit r, input bit w, input logic [27:0] a,
                       input logic [LineW-1:0] d, input int lat,
                       input logic [LineW-1:0] exp_rd);
    exp_t e;
    bit   seen = 1'b0;
    @(posedge clk);
    e.rdata     = (r && !w) ? exp_rd : last_rd[id];
    last_rd[id] = e.rdata;
    e.cyc       = cyc + 1 + lat;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    drive(id, r, w, a, d);
    for (int i = 0; i < lat + 4 && !seen; i++) begin
      @(posedge clk);
      if (i == 0) drive(id, r, w, ~a, ~d);
      seen = (get_ready(id) === 1'b1);
    end
    drive(id, 1'b0, 1'b0, a, d);
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ready_timeout dut%0d: got no ready, expected ready within %0d cycles",
               id, lat);
    end
  endtask

  task automatic reset_checks(input string tag);
    for (int id = 0; id < 3; id++) begin
      check($sformatf("%s_ready dut%0d", tag, id), LineW'(get_ready(id)), '0);
      check($sformatf("%s_rdata dut%0d", tag, id), get_rdata(id), '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int id = 0; id < 3; id++) begin
      drive(id, 1'b0, 1'b0, '0, '0);
      last_rd[id] = '0;
    end

    // Reset held for 3 cycles, then idle with no request.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check("idle_ready dut0", LineW'(get_ready(0)), '0);

    // Default latencies, write then read, wrap, read/write conflict.
    issue(0, 1'b0, 1'b1, 28'h5,   LineA, 15, '0);
    issue(0, 1'b1, 1'b0, 28'h5,   '0,    15, LineA);
    issue(0, 1'b0, 1'b1, 28'h105, LineB, 15, '0);
    issue(0, 1'b1, 1'b0, 28'h005, '0,    15, LineB);
    issue(0, 1'b0, 1'b1, 28'h6,   LineD, 15, '0);
    issue(0, 1'b1, 1'b0, 28'h6,   '0,    15, LineD);
    issue(0, 1'b1, 1'b1, 28'h5,   LineC, 15, '0);
    issue(0, 1'b1, 1'b0, 28'h5,   '0,    15, LineB);

    // Asymmetric latencies and a conflict on the short read latency.
    issue(1, 1'b0, 1'b1, 28'h3,   LineF, 7, '0);
    issue(1, 1'b1, 1'b0, 28'h3,   '0,    3, LineF);
    issue(1, 1'b1, 1'b1, 28'h3,   LineC, 3, '0);
    issue(1, 1'b1, 1'b0, 28'h3,   '0,    3, LineF);

    // Single-cycle latency with a 16-line array: 0x13 aliases 0x3.
    issue(2, 1'b0, 1'b1, 28'h13,  LineG, 1, '0);
    issue(2, 1'b1, 1'b0, 28'h3,   '0,    1, LineG);

    // Reset in the middle of a write: no ready, old line survives.
    issue(0, 1'b0, 1'b1, 28'h9,   LineE, 15, '0);
    issue(0, 1'b1, 1'b0, 28'h9,   '0,    15, LineE);
    @(posedge clk);
    drive(0, 1'b0, 1'b1, 28'h9, '1);
    repeat (6) @(posedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    reset_checks("midreset");
    rst_n = 1'b1;
    for (int id = 0; id < 3; id++) last_rd[id] = '0;
    repeat (2) @(posedge clk);
    issue(0, 1'b1, 1'b0, 28'h9,   '0,    15, LineE);

`ifdef SLOW_MEM_BYTE_MASK_EN
    wmask_cur = '1;
    issue(0, 1'b0, 1'b1, 28'h2, '0, 15, '0);
    wmask_cur = 16'h000F;
    issue(0, 1'b0, 1'b1, 28'h2, '1, 15, '0);
    issue(0, 1'b1, 1'b0, 28'h2, '0, 15, 128'h00000000_00000000_00000000_FFFFFFFF);
    wmask_cur = 16'h0000;
    issue(0, 1'b0, 1'b1, 28'h2, '1, 15, '0);
    issue(0, 1'b1, 1'b0, 28'h2, '0, 15, 128'h00000000_00000000_00000000_FFFFFFFF);
    wmask_cur = '1;
`endif

    repeat (25) @(posedge clk);
    check("leftover dut0", LineW'(q0.size()), '0);
    check("leftover dut1", LineW'(q1.size()), '0);
    check("leftover dut2", LineW'(q2.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slow_memory_pl.md
# slow_memory_pl

Parametrised, synthesisable main-memory model with a one-cycle `mem_ready` handshake.
- Successor to the fixed 256×128-bit behavioural slow memory. Sits behind the I/D caches in the RISCV baseline.
- Generalises word width, words per line, depth, and separate read and write latencies.
- Latency is counted in clock cycles, with no `#` delays, and the block has an asynchronous reset.
- Requests are captured once on acceptance rather than re-sampled every cycle.

## Interface
Parameters:
- `WORD_W`, 32: bits per word.
- `WORDS_PER_LINE`, 4: words per line. `LINE_W = WORD_W*WORDS_PER_LINE`.
- `MEM_LINES`, 256: number of lines. Must be a power of two. `IDX_W = log2(MEM_LINES)`.
- `ADDR_W`, 28: line-address width.
- `RD_LATENCY`, 15: cycles from request sample to `mem_ready` for a read. Minimum 1.
- `WR_LATENCY`, 15: the same, for a write. Minimum 1.

Ports:
- `clk`, in, 1: clock. All state updates on the negedge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `mem_read`, in, 1: read request. Level, held until `mem_ready`.
- `mem_write`, in, 1: write request. Level, held until `mem_ready`.
- `mem_addr`, in, `ADDR_W`: line address. Only the low `IDX_W` bits are used.
- `mem_wdata`, in, `LINE_W`: write line. Word 0 is in bits `[WORD_W-1:0]`.
- `mem_wmask`, in, `LINE_W/8`: byte write enables. Present only with `SLOW_MEM_BYTE_MASK_EN`.
- `mem_rdata`, out, `LINE_W`: read line, registered.
- `mem_ready`, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, WAIT, DONE. A down-counter `cnt` is sized to hold `max(RD_LATENCY, WR_LATENCY)-1`.
- **IDLE:**
  - If `mem_read|mem_write` is high, capture read, write, `addr[IDX_W-1:0]`, wdata and wmask.
  - Load `cnt` with `RD_LATENCY-1` if read is set, otherwise `WR_LATENCY-1`. Go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT:**
  - While `cnt != 0`: decrement `cnt`.
  - When `cnt == 0`: perform the access, set `mem_ready` to 1, go to DONE.
- **DONE:** `mem_ready` goes to 0; go to IDLE.
- **Access:**
  - Read only: `mem_rdata` is set to the line at the index, arranged as word `i` at bits `[i*WORD_W +: WORD_W]`.
  - Write only: the line at the index is set to the captured wdata. `mem_rdata` is unchanged.
  - Read and write both set: no array access and `mem_rdata` unchanged. The handshake still completes, using `RD_LATENCY`.
- Inputs are ignored outside IDLE. Changing `mem_addr` or `mem_wdata` mid-transaction has no effect.
- Address bits above `IDX_W` are ignored, so addresses wrap modulo `MEM_LINES`.
- **Reset (`rst_n` = 0), at any time, including mid-transaction:**
  - state goes to IDLE, `cnt` to 0, `mem_ready` to 0, `mem_rdata` to 0.
  - A captured but unperformed write is discarded.
  - Array contents are not cleared by reset.

## Timing
- Request sampled at negedge k, with state IDLE:
  - `mem_ready` rises at negedge k+L and falls at negedge k+L+1.
  - L is `RD_LATENCY` or `WR_LATENCY`.
- `mem_rdata` is valid from negedge k+L and held until the next read completes or reset.
- A write is visible to a read issued any time after `mem_ready` falls.
- Back-to-back: state is IDLE from negedge k+L+1, so the earliest next sample is at negedge k+L+2.
  - A requester that drops its request on seeing `mem_ready` (sampled on posedge) starts no spurious transaction.
  - A request still high at k+L+2 starts a new transaction.
- Reset is asserted asynchronously. Release takes effect at the next negedge.

## Configuration
- `SLOW_MEM_BYTE_MASK_EN` defined:
  - The `mem_wmask` port exists and is captured with the request.
  - On write, only bytes whose mask bit is 1 are updated; bit `b` covers line bits `[8b+7:8b]`.
  - A mask of all 0 performs no update, but the handshake still completes.
- Not defined:
  - The port is absent and every write updates the full line.
  - Reads are identical in both builds.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → `mem_ready`=0 and `mem_rdata`=0. Release, no request → still IDLE, `mem_ready`=0.
- **Write then read, defaults:**
  - Write addr 0x5 with `0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA`, sampled at negedge k → `mem_ready` high exactly during negedges k+15..k+16.
  - Then read addr 0x5 → `mem_rdata` equals that line at the ready negedge.
- **Latencies:** `RD_LATENCY`=3, `WR_LATENCY`=7 → read ready 3 cycles after sample, write ready 7 cycles after sample. `RD_LATENCY`=1 → ready at k+1.
- **Wrap and read/write conflict:**
  - Write addr 0x105 with `MEM_LINES`=256 → read addr 0x005 returns the written data.
  - Read+write together at addr 0x5 → ready pulses after `RD_LATENCY`, while line 0x5 and `mem_rdata` stay unchanged.
- **Reset mid-transaction:**
  - Assert `rst_n`=0 during WAIT of a write of 0xFF..FF to addr 0x9 → no ready pulse, and a later read of 0x9 returns the old contents.
  - Inputs that change during WAIT do not alter the result.
- **Byte mask (`SLOW_MEM_BYTE_MASK_EN`):**
  - Line 0x2 = all 0x00; write all 0xFF with mask 0x000F → read returns `0x...00000000_FFFFFFFF`, low word only.
  - Mask 0x0000 → line unchanged, and ready still pulses.
